// File: rtl/vga_timing_gen.sv
// Raster timing generator: scan counters, one-cycle registered colour/sync
// pipeline and a once-per-frame tick at the start of vertical blank.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 1440,
    parameter int unsigned H_FP     = 80,
    parameter int unsigned H_SYNC   = 152,
    parameter int unsigned H_BP     = 232,
    parameter int unsigned V_ACTIVE = 900,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 28,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  draw_r,
    input  logic [3:0]  draw_g,
    input  logic [3:0]  draw_b,
    output logic [10:0] curr_x,
    output logic [9:0]  curr_y,
    output logic        active,
    output logic [3:0]  pix_r,
    output logic [3:0]  pix_g,
    output logic [3:0]  pix_b,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_tick
);

    localparam int unsigned XW      = 11;
    localparam int unsigned YW      = 10;
    localparam int unsigned CW      = 4;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic x_wrap_c;
    logic y_wrap_c;
    logic hs_win_c;
    logic vs_win_c;
    logic tick_c;

    always_comb begin
        x_wrap_c = (curr_x == X_LAST);
        y_wrap_c = (curr_y == Y_LAST);
        hs_win_c = (curr_x >= HS_START) && (curr_x <= HS_END);
        vs_win_c = (curr_y >= VS_START) && (curr_y <= VS_END);
        tick_c   = (curr_x == '0) && (curr_y == Y_ACT);
    end

    assign active = (curr_x < X_ACT) && (curr_y < Y_ACT);

    // Scan counters: y advances only on the x wrap, both wrap together at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            curr_x <= '0;
            curr_y <= '0;
        end else if (x_wrap_c) begin
            curr_x <= '0;
            curr_y <= y_wrap_c ? '0 : curr_y + YW'(1);
        end else begin
            curr_x <= curr_x + XW'(1);
        end
    end

    // Output stage: everything reflects the previous cycle's counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_r      <= '0;
            pix_g      <= '0;
            pix_b      <= '0;
            hsync      <= ~HS_POL;
            vsync      <= ~VS_POL;
            frame_tick <= 1'b0;
        end else begin
            pix_r      <= active ? draw_r : CW'(0);
            pix_g      <= active ? draw_g : CW'(0);
            pix_b      <= active ? draw_b : CW'(0);
            hsync      <= hs_win_c ? HS_POL : ~HS_POL;
            vsync      <= vs_win_c ? VS_POL : ~VS_POL;
            frame_tick <= tick_c;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunken-timing instance checked every cycle
// against an arithmetic raster model, plus a full 1440x900 instance for line timing.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 4, HSW = 6, HB = 6;
    localparam int VA = 10, VF = 1, VSW = 3, VB = 2;
    localparam int HT = HA + HF + HSW + HB;   // 32
    localparam int VT = VA + VF + VSW + VB;   // 16
    localparam int FT = HT * VT;              // 512

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] rnd_r = '0, rnd_g = '0, rnd_b = '0;
    int mode = 1;
    logic [3:0] draw_r, draw_g, draw_b;

    logic [10:0] curr_x;  logic [9:0] curr_y;  logic active;
    logic [3:0] pix_r, pix_g, pix_b;  logic hsync, vsync, frame_tick;

    logic [10:0] f_x;  logic [9:0] f_y;  logic f_active;
    logic [3:0] f_r, f_g, f_b;  logic f_hs, f_vs, f_ft;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Mode 2 emulates draw logic that paints curr_x[3:0] in red.
    assign draw_r = (mode == 2) ? curr_x[3:0] : rnd_r;
    assign draw_g = rnd_g;
    assign draw_b = rnd_b;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
        .curr_x(curr_x), .curr_y(curr_y), .active(active),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
    );

    vga_timing_gen dut_full (
        .clk(clk), .rst(rst), .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
        .curr_x(f_x), .curr_y(f_y), .active(f_active),
        .pix_r(f_r), .pix_g(f_g), .pix_b(f_b),
        .hsync(f_hs), .vsync(f_vs), .frame_tick(f_ft)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Raster model: k counts pixels since reset; position is k split into line/pixel.
    int   k = 0;
    bit   model_valid = 1'b0;
    logic [11:0] e_pix = '0;
    logic e_hs = 1'b1, e_vs = 1'b0, e_ft = 1'b0;
    int   mx, my;
    bit   mact;

    always @(posedge clk) begin
        if (rst) begin
            k <= 0;
            e_pix <= '0;
            e_hs <= 1'b1;
            e_vs <= 1'b0;
            e_ft <= 1'b0;
            model_valid <= 1'b1;
        end else if (model_valid) begin
            mx = k % HT;
            my = k / HT;
            mact = (mx < HA) && (my < VA);
            e_pix <= mact ? {draw_r, draw_g, draw_b} : 12'h000;
            e_hs <= !((mx >= HA + HF) && (mx < HA + HF + HSW));
            e_vs <= (my >= VA + VF) && (my < VA + VF + VSW);
            e_ft <= (mx == 0) && (my == VA);
            k <= (k + 1) % FT;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("curr_x", int'(curr_x), k % HT);
            chk("curr_y", int'(curr_y), k / HT);
            chk("active", int'(active), int'(((k % HT) < HA) && ((k / HT) < VA)));
            chk("pix", int'({pix_r, pix_g, pix_b}), int'(e_pix));
            chk("hsync", int'(hsync), int'(e_hs));
            chk("vsync", int'(vsync), int'(e_vs));
            chk("frame_tick", int'(frame_tick), int'(e_ft));
        end
    end

    // Edge-to-edge timing measured against hand-computed literals.
    bit meas_en = 1'b0;
    int cyc, hf, vr, ftc, run, f_hf, f_run;
    logic p_hs, p_vs, pf_hs;

    always @(negedge clk) begin
        if (!meas_en) begin
            cyc = 0; hf = -1; vr = -1; ftc = -1; run = 0; f_hf = -1; f_run = 0;
        end else begin
            cyc++;
            if (p_hs && !hsync) begin
                if (hf >= 0) chk("hs_period", cyc - hf, 32);
                hf = cyc;
            end
            if (!p_hs && hsync && hf >= 0) chk("hs_width", cyc - hf, 6);
            if (!p_vs && vsync) begin
                if (vr >= 0) chk("vs_period", cyc - vr, 512);
                vr = cyc;
            end
            if (p_vs && !vsync && vr >= 0) chk("vs_width", cyc - vr, 96);
            if (frame_tick) begin
                if (ftc >= 0) chk("tick_period", cyc - ftc, 512);
                ftc = cyc;
            end
            if ({pix_r, pix_g, pix_b} == 12'hFFF) run++;
            else begin
                if (run > 0) chk("pix_run", run, 16);
                run = 0;
            end
            if (pf_hs && !f_hs) begin
                if (f_hf >= 0) chk("full_hs_period", cyc - f_hf, 1904);
                f_hf = cyc;
            end
            if (!pf_hs && f_hs && f_hf >= 0) chk("full_hs_width", cyc - f_hf, 152);
            if ({f_r, f_g, f_b} == 12'hFFF) f_run++;
            else begin
                if (f_run > 0) chk("full_pix_run", f_run, 1440);
                f_run = 0;
            end
        end
        p_hs = hsync;
        p_vs = vsync;
        pf_hs = f_hs;
    end

    initial begin
        int n;
        // Constant white over ~8 small frames and two full-size lines.
        mode = 1;
        rnd_r = 4'hF; rnd_g = 4'hF; rnd_b = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        meas_en = 1'b1;
        repeat (4200) @(negedge clk);
        meas_en = 1'b0;

        // Random colours (garbage during blanking), random short resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) mode = int'($urandom_range(0, 2));
            rnd_r = 4'($urandom); rnd_g = 4'($urandom); rnd_b = 4'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        mode = 0;

        // One-cycle reset inside both sync pulses at (22,12).
        n = 0;
        while (k != 12 * HT + 22 && n < 2 * FT) begin
            @(negedge clk);
            n++;
        end
        chk("reach_22_12", n < 2 * FT ? 1 : 0, 1);
        chk("pre_rst_hsync", int'(hsync), 0);
        chk("pre_rst_vsync", int'(vsync), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 0);
        chk("rst_pix", int'({pix_r, pix_g, pix_b}), 0);
        chk("rst_x", int'(curr_x), 0);
        chk("rst_y", int'(curr_y), 0);
        chk("rst_full_x", int'(f_x), 0);
        n = 0;
        while (hsync !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("hs_after_release", n, 21);

        // Walk across the frame wrap corner.
        n = 0;
        while (!(curr_x == 11'(HT - 1) && curr_y == 10'(VT - 1)) && n < 2 * FT) begin
            @(negedge clk);
            n++;
        end
        chk("reach_corner", n < 2 * FT ? 1 : 0, 1);
        @(negedge clk);
        chk("corner_x", int'(curr_x), 0);
        chk("corner_y", int'(curr_y), 0);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the 1440x900@60 display path, clocked from the 106 MHz pixel clock.
- Produces the scan coordinates `curr_x`/`curr_y` that the draw logic uses to compute colour.
- Registers the returned `draw_r/g/b` colour onto the VGA pins, blanked outside the active area, aligned with `hsync`/`vsync`.
- Emits a once-per-frame `frame_tick` so game logic updates object positions during vertical blank, not from a divided clock.

Parameters:
- H_ACTIVE, 1440, visible pixels per line
- H_FP, 80, horizontal front porch (pixels)
- H_SYNC, 152, horizontal sync width (pixels)
- H_BP, 232, horizontal back porch (pixels); line total 1904
- V_ACTIVE, 900, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width (lines)
- V_BP, 28, vertical back porch (lines); frame total 932
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 1, vsync asserted level (1 = active-high)

Ports:
- clk  in  1  pixel clock (106 MHz)
- rst  in  1  synchronous active-high reset
- draw_r  in  4  red from draw logic for current curr_x/curr_y
- draw_g  in  4  green from draw logic
- draw_b  in  4  blue from draw logic
- curr_x  out  11  horizontal counter, 0..H_TOTAL-1
- curr_y  out  10  vertical counter, 0..V_TOTAL-1
- active  out  1  1 when curr_x<H_ACTIVE and curr_y<V_ACTIVE
- pix_r  out  4  registered red to DAC
- pix_g  out  4  registered green to DAC
- pix_b  out  4  registered blue to DAC
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- frame_tick  out  1  one-cycle pulse at start of vertical blank

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `rst`, sampled on the rising edge of `clk`. No other clocks or async paths.
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
- Counters: `curr_x` and `curr_y` are registers.
  - `curr_x` increments every cycle and wraps H_TOTAL-1 -> 0.
  - `curr_y` increments only on the cycle `curr_x` wraps, and wraps V_TOTAL-1 -> 0 on that same cycle.
  - Arithmetic is unsigned; counters never exceed TOTAL-1.
- `active` is combinational from the counters (same cycle as `curr_x`/`curr_y`).
- Draw interface: the draw logic is combinational from `curr_x`/`curr_y`. `draw_*` is sampled in the same cycle the coordinates are presented.
- Output pipeline: exactly one cycle of latency.
  - For counter state (x,y) in cycle n, `pix_*`, `hsync` and `vsync` in cycle n+1 reflect (x,y).
  - `pix_*` = `draw_*` if `active`(n), else 4'h0.
  - `hsync` = HS_POL when x is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [1520,1671], else ~HS_POL.
  - `vsync` = VS_POL when y is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [901,903], else ~VS_POL. vsync is evaluated per pixel, so its edges coincide with the x=0 cycle of line 901/904, delayed by 1.
- `frame_tick`: registered. High for exactly one cycle, the cycle after counter state (0, V_ACTIVE). Exactly one pulse per frame.
- Reset (including mid-frame):
  - next cycle `curr_x`=0, `curr_y`=0.
  - `pix_*`=0.
  - `hsync`=~HS_POL, `vsync`=~VS_POL.
  - `frame_tick`=0.
  - Counting resumes from (0,0) on the first cycle with `rst` low.
  - No partial sync pulse is extended across reset.
- `draw_*` values during blanking are ignored. X/garbage on `draw_*` in blanking must not reach `pix_*`.
- Parameter changes must not need RTL edits. Counter widths are fixed at 11/10 bits; H_TOTAL ≤ 2048 and V_TOTAL ≤ 1024.

Test Plan:
- Reset then free-run 2 frames -> period between `hsync` falling edges is 1904 cycles, low width 152. Period between `vsync` rising edges is 1904*932 = 1774528 cycles, high width 3*1904 = 5712.
- Drive `draw_*`=4'hF constantly -> `pix_*`=F in exactly 1440 consecutive cycles per line on lines 0..899, 0 otherwise. The first F appears the cycle after (`curr_x`,`curr_y`)=(0,0).
- Drive `draw_r` = `curr_x[3:0]` -> `pix_r` in cycle n+1 equals `curr_x[3:0]` from cycle n. At `curr_x`=1439->1440 the output drops to 0 one cycle later.
- Check `frame_tick` -> exactly one pulse per 1774528 cycles, the cycle after (0,900). Zero pulses during reset.
- Assert `rst` for 1 cycle at (`curr_x`,`curr_y`)=(1600,902), inside both sync pulses -> next cycle `hsync`=1, `vsync`=0, `pix_*`=0, counters at (0,0). The next `hsync` assertion comes 1520+1 cycles after release.
- Wrap corner: observe (1903,931) -> next state (0,0) in one step, no extra line or pixel. `curr_y` never reads 932.
